// File: rtl/dtw_pkg.sv
// Shared constants and state encoding for the DTW datapath stages.
// Sample/template width, template capacity and the widened cost width live here.
package dtw_pkg;

    localparam int DW   = 16;
    localparam int TLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = DW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/dtw_absdiff.sv
// Combinational signed |a - b|, widened by one bit so the result never overflows.
module dtw_absdiff
    import dtw_pkg::*;
(
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic        [CW-1:0] y
);

    logic [CW-1:0] diff;

    always_comb begin
        diff = {a[DW-1], a} - {b[DW-1], b};
        y    = diff[CW-1] ? (~diff + CW'(1)) : diff;
    end

endmodule

// File: rtl/dtw_local_cost.sv
// Pops one sample per column from a show-ahead FIFO and streams |x - t[j]| for
// j = 0..len-1 against a register-held template over a valid/ready port.
module dtw_local_cost
    import dtw_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic signed [DW-1:0] fifo_q,
    input  logic                 fifo_empty,
    output logic                 fifo_rdreq,
    input  logic                 tpl_we,
    input  logic [AW-1:0]        tpl_addr,
    input  logic signed [DW-1:0] tpl_data,
    input  logic [AW:0]          tpl_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_cost,
    output logic [AW-1:0]        out_j,
    output logic                 out_first,
    output logic                 out_last,
    output logic [15:0]          out_col,
    output logic                 busy
);

    state_t                state_reg;
    logic signed [DW-1:0]  x_reg;
    logic [AW:0]           len_reg;
    logic signed [DW-1:0]  tpl_mem [TLEN];

    logic                  len_ok;
    logic                  start;
    logic [AW-1:0]         next_j;
    logic [AW-1:0]         rd_idx;
    logic signed [DW-1:0]  diff_a;
    logic signed [DW-1:0]  diff_b;
    logic [CW-1:0]         beat_cost;
    logic                  next_last;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TLEN; i++) begin
                tpl_mem[i] <= '0;
            end
        end else if (tpl_we) begin
            tpl_mem[tpl_addr] <= tpl_data;
        end
    end

    // Out-of-range lengths park the block in IDLE rather than popping a sample.
    assign len_ok = (tpl_len != '0) && (tpl_len <= (AW+1)'(TLEN));
    assign start  = (state_reg == IDLE) && enable && !fifo_empty && len_ok && !clear;

    // Gated by rst_n so the strobe is already low while reset is held.
    assign fifo_rdreq = start && rst_n;
    assign busy       = (state_reg != IDLE);

    // One subtractor serves both the first beat (fifo head vs t[0]) and later beats.
    assign next_j    = out_j + AW'(1);
    assign rd_idx    = (state_reg == IDLE) ? '0 : next_j;
    assign diff_a    = (state_reg == IDLE) ? fifo_q : x_reg;
    assign diff_b    = tpl_mem[rd_idx];
    assign next_last = ({1'b0, next_j} == (len_reg - (AW+1)'(1)));

    dtw_absdiff u_absdiff (
        .a (diff_a),
        .b (diff_b),
        .y (beat_cost)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            len_reg   <= '0;
            out_valid <= 1'b0;
            out_cost  <= '0;
            out_j     <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_col   <= '0;
        end else if (clear) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_col   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= EMIT;
                        x_reg     <= fifo_q;
                        len_reg   <= tpl_len;
                        out_valid <= 1'b1;
                        out_cost  <= beat_cost;
                        out_j     <= '0;
                        out_first <= 1'b1;
                        out_last  <= (tpl_len == (AW+1)'(1));
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_reg <= IDLE;
                            out_valid <= 1'b0;
                            out_col   <= out_col + 16'd1;
                        end else begin
                            out_j     <= next_j;
                            out_cost  <= beat_cost;
                            out_first <= 1'b0;
                            out_last  <= next_last;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
